// File: rtl/fpu_pkg.sv
// Shared FPU definitions: ALU-op codes, rounding modes, flag indices, integer saturation values.
package fpu_pkg;

  localparam logic [4:0] FSGNJ_S  = 5'b10001;
  localparam logic [4:0] FSGNJN_S = 5'b10010;
  localparam logic [4:0] FSGNJX_S = 5'b10011;
  localparam logic [4:0] FCVT_W   = 5'b10100;
  localparam logic [4:0] FCVT_WU  = 5'b10101;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

  // Unpacked operand after alignment; huge marks |x| >= 2^32.
  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        inf;
    logic        huge;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic [4:0]  op;
    logic [2:0]  rm;
  } s1_t;

endpackage

// File: rtl/fpu_round_sat.sv
// Stage-2 combinational logic: round the aligned magnitude, negate, saturate, raise NV/NX.
module fpu_round_sat import fpu_pkg::*; (
  input  s1_t         s1,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  logic        inc;
  logic        inexact;
  logic        nv;
  logic [32:0] rnd;
  logic [31:0] neg;

  assign inexact = s1.guard | s1.sticky;

  always_comb begin
    case (s1.rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = s1.sign & inexact;
      RUP:     inc = ~s1.sign & inexact;
      RMM:     inc = s1.guard;
      default: inc = s1.guard & (s1.sticky | s1.mag[0]);
    endcase
  end

  assign rnd = {1'b0, s1.mag} + {32'd0, inc};
  assign neg = ~rnd[31:0] + 32'd1;

  always_comb begin
    result = 32'd0;
    nv     = 1'b0;
    flags  = 5'd0;
    if (s1.op == FCVT_W) begin
      if (s1.nan || (s1.inf && !s1.sign)) begin
        result = INT_MAX;
        nv     = 1'b1;
      end else if (s1.inf || s1.huge) begin
        result = s1.sign ? INT_MIN : INT_MAX;
        nv     = 1'b1;
      end else if (!s1.sign) begin
        nv     = rnd > 33'h0_7FFF_FFFF;
        result = nv ? INT_MAX : rnd[31:0];
      end else begin
        // -2^31 itself is representable
        nv     = rnd > 33'h0_8000_0000;
        result = nv ? INT_MIN : neg;
      end
      flags[FLAG_NV] = nv;
      flags[FLAG_NX] = inexact & ~nv;
    end else if (s1.op == FCVT_WU) begin
      if (s1.nan || (!s1.sign && (s1.inf || s1.huge || rnd[32]))) begin
        result = UINT_MAX;
        nv     = 1'b1;
      end else if (s1.sign) begin
        result = 32'd0;
        nv     = s1.inf | s1.huge | (rnd != 33'd0);
      end else begin
        result = rnd[31:0];
      end
      flags[FLAG_NV] = nv;
      flags[FLAG_NX] = inexact & ~nv;
    end
  end

endmodule

// File: rtl/fpu_cvt_f2i.sv
// Two-stage FCVT.W.S / FCVT.WU.S converter with valid/ready handshake on both sides.
// Define FPU_CVT_FFLAGS_EN to drive o_fflags; otherwise the flag outputs are tied to zero.
module fpu_cvt_f2i import fpu_pkg::*; (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_operand_a,
  input  logic [4:0]  i_alu_op,
  input  logic [2:0]  i_rm,
  input  logic [4:0]  i_rd_addr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd_addr,
  output logic [4:0]  o_fflags
);

  s1_t         s1_d, s1_q;
  logic [4:0]  s1_tag_q;
  logic        s1_valid_q;
  logic        s1_advance;
  logic        accept;

  logic [7:0]        exp_f;
  logic [22:0]       man_f;
  logic [23:0]       sig;
  logic signed [9:0] e;
  logic [3:0]        lsh;
  logic [4:0]        rsh;
  logic [48:0]       ext;

  logic [31:0] result_d, result_q;
  logic [4:0]  flags_d;
  logic        valid_q;
  logic [4:0]  rd_q;

  assign exp_f = i_operand_a[30:23];
  assign man_f = i_operand_a[22:0];
  assign sig   = {exp_f != 8'd0, man_f};
  assign e     = (exp_f == 8'd0) ? -10'sd126 : $signed({2'b00, exp_f}) - 10'sd127;
  assign lsh   = 4'(e - 10'sd23);
  assign rsh   = 5'(10'sd23 - e);
  assign ext   = {sig, 25'd0} >> rsh;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = i_operand_a[31];
    s1_d.nan  = (exp_f == 8'hFF) && (man_f != 23'd0);
    s1_d.inf  = (exp_f == 8'hFF) && (man_f == 23'd0);
    s1_d.op   = i_alu_op;
    s1_d.rm   = i_rm;
    if (exp_f != 8'hFF) begin
      if (e > 10'sd31) begin
        s1_d.huge = 1'b1;
      end else if (e >= 10'sd23) begin
        s1_d.mag = {8'd0, sig} << lsh;
      end else if (e >= -10'sd1) begin
        s1_d.mag    = {8'd0, ext[48:25]};
        s1_d.guard  = ext[24];
        s1_d.sticky = |ext[23:0];
      end else begin
        s1_d.sticky = |sig;
      end
    end
  end

  assign s1_advance = s1_valid_q && (!valid_q || i_ready);
  assign o_ready    = !s1_valid_q || s1_advance;
  assign accept     = i_valid && o_ready;

  fpu_round_sat u_round_sat (
    .s1     (s1_q),
    .result (result_d),
    .flags  (flags_d)
  );

  // Flush wins over both accept and drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_tag_q   <= 5'd0;
      valid_q    <= 1'b0;
      result_q   <= 32'd0;
      rd_q       <= 5'd0;
    end else begin
      if (i_flush)         s1_valid_q <= 1'b0;
      else if (accept)     s1_valid_q <= 1'b1;
      else if (s1_advance) s1_valid_q <= 1'b0;
      if (accept) begin
        s1_q     <= s1_d;
        s1_tag_q <= i_rd_addr;
      end
      if (i_flush)         valid_q <= 1'b0;
      else if (s1_advance) valid_q <= 1'b1;
      else if (i_ready)    valid_q <= 1'b0;
      if (s1_advance) begin
        result_q <= result_d;
        rd_q     <= s1_tag_q;
      end
    end
  end

`ifdef FPU_CVT_FFLAGS_EN
  logic [4:0] flags_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        flags_q <= 5'd0;
    else if (s1_advance) flags_q <= flags_d;
  end

  assign o_fflags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags_d;
  assign o_fflags     = 5'd0;
`endif

  assign o_valid   = valid_q;
  assign o_result  = result_q;
  assign o_rd_addr = rd_q;

endmodule

// File: tb/tb_fpu_cvt_f2i.sv
// Directed bench for fpu_cvt_f2i: conversion vectors, back-pressure ordering, flush and reset.
module tb_fpu_cvt_f2i;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_operand_a;
  logic [4:0]  i_alu_op;
  logic [2:0]  i_rm;
  logic [4:0]  i_rd_addr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;
  logic [4:0]  o_fflags;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] W   = 5'b10100;
  localparam logic [4:0] WU  = 5'b10101;
  localparam logic [4:0] NV  = 5'b10000;
  localparam logic [4:0] NX  = 5'b00001;
  localparam logic [4:0] NOF = 5'b00000;

  fpu_cvt_f2i dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_operand_a (i_operand_a),
    .i_alu_op    (i_alu_op),
    .i_rm        (i_rm),
    .i_rd_addr   (i_rd_addr),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_rd_addr   (o_rd_addr),
    .o_fflags    (o_fflags)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] xf(input logic [4:0] f);
`ifdef FPU_CVT_FFLAGS_EN
    return f;
`else
    return 5'd0 & f;
`endif
  endfunction

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [4:0]  op;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic [31:0] a, input logic [4:0] op, input logic [2:0] rm,
                       input logic [4:0] tag);
    i_valid     = 1'b1;
    i_operand_a = a;
    i_alu_op    = op;
    i_rm        = rm;
    i_rd_addr   = tag;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (o_valid) break;
      @(negedge i_clk);
    end
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
  endtask

  initial begin
    vecs.push_back('{"rne_2p5",  32'h4020_0000, W,  3'b000, 32'h0000_0002, NX});
    vecs.push_back('{"rup_2p5",  32'h4020_0000, W,  3'b011, 32'h0000_0003, NX});
    vecs.push_back('{"rmm_2p5",  32'h4020_0000, W,  3'b100, 32'h0000_0003, NX});
    vecs.push_back('{"rtz_2p5",  32'h4020_0000, W,  3'b001, 32'h0000_0002, NX});
    vecs.push_back('{"rm7_2p5",  32'h4020_0000, W,  3'b111, 32'h0000_0002, NX});
    vecs.push_back('{"rdn_m2p5", 32'hC020_0000, W,  3'b010, 32'hFFFF_FFFD, NX});
    vecs.push_back('{"w_min",    32'hCF00_0000, W,  3'b000, 32'h8000_0000, NOF});
    vecs.push_back('{"w_ovf",    32'h4F00_0000, W,  3'b000, 32'h7FFF_FFFF, NV});
    vecs.push_back('{"wu_2p31",  32'h4F00_0000, WU, 3'b000, 32'h8000_0000, NOF});
    vecs.push_back('{"w_nan",    32'h7FC0_0000, W,  3'b000, 32'h7FFF_FFFF, NV});
    vecs.push_back('{"wu_nan",   32'h7FC0_0000, WU, 3'b000, 32'hFFFF_FFFF, NV});
    vecs.push_back('{"wu_m0p5z", 32'hBF00_0000, WU, 3'b001, 32'h0000_0000, NX});
    vecs.push_back('{"wu_m0p5d", 32'hBF00_0000, WU, 3'b010, 32'h0000_0000, NV});
    vecs.push_back('{"w_ninf",   32'hFF80_0000, W,  3'b000, 32'h8000_0000, NV});
    vecs.push_back('{"wu_2p32",  32'h4F80_0000, WU, 3'b000, 32'hFFFF_FFFF, NV});
    vecs.push_back('{"w_one",    32'h3F80_0000, W,  3'b000, 32'h0000_0001, NOF});
    vecs.push_back('{"w_negz",   32'h8000_0000, W,  3'b011, 32'h0000_0000, NOF});
    vecs.push_back('{"bad_op",   32'h4020_0000, 5'b00000, 3'b000, 32'h0000_0000, NOF});

    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    i_valid = 1'b0;
    drive(32'd0, W, 3'b000, 5'd0);
    i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_valid",  {31'd0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_rd",     {27'd0, o_rd_addr}, 32'd0);
    check("rst_flags",  {27'd0, o_fflags}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ready",  {31'd0, o_ready}, 32'd1);

    foreach (vecs[k]) begin
      drive(vecs[k].a, vecs[k].op, vecs[k].rm, 5'(k + 10));
      @(negedge i_clk);
      i_valid = 1'b0;
      wait_valid(vecs[k].name);
      check({vecs[k].name, "_res"}, o_result, vecs[k].res);
      check({vecs[k].name, "_fl"},  {27'd0, o_fflags}, {27'd0, xf(vecs[k].fl)});
      check({vecs[k].name, "_rd"},  {27'd0, o_rd_addr}, 32'(k + 10));
      @(negedge i_clk);
    end

    // Back-pressure: three ops, writeback stalled two cycles.
    i_ready = 1'b0;
    drive(32'h4020_0000, W, 3'b000, 5'd1);
    @(negedge i_clk);
    drive(32'h4020_0000, W, 3'b011, 5'd2);
    @(negedge i_clk);
    drive(32'hC020_0000, W, 3'b010, 5'd3);
    check("bp_valid",  {31'd0, o_valid}, 32'd1);
    check("bp_ready0", {31'd0, o_ready}, 32'd0);
    check("bp_rd1a",   {27'd0, o_rd_addr}, 32'd1);
    check("bp_res1a",  o_result, 32'd2);
    @(negedge i_clk);
    check("bp_ready1", {31'd0, o_ready}, 32'd0);
    check("bp_rd1b",   {27'd0, o_rd_addr}, 32'd1);
    check("bp_res1b",  o_result, 32'd2);
    check("bp_fl1",    {27'd0, o_fflags}, {27'd0, xf(NX)});
    i_ready = 1'b1;
    #1;
    check("bp_ready2", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("bp_rd2",    {27'd0, o_rd_addr}, 32'd2);
    check("bp_res2",   o_result, 32'd3);
    @(negedge i_clk);
    check("bp_rd3",    {27'd0, o_rd_addr}, 32'd3);
    check("bp_res3",   o_result, 32'hFFFF_FFFD);
    @(negedge i_clk);
    check("bp_empty",  {31'd0, o_valid}, 32'd0);

    // Flush with both stages full and a new op presented.
    i_ready = 1'b0;
    drive(32'h3F80_0000, W, 3'b000, 5'd4);
    @(negedge i_clk);
    drive(32'h4000_0000, W, 3'b000, 5'd5);
    @(negedge i_clk);
    drive(32'h4040_0000, W, 3'b000, 5'd6);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    check("fl_valid0", {31'd0, o_valid}, 32'd0);
    begin
      int seen = 0;
      repeat (4) begin
        @(negedge i_clk);
        seen += int'(o_valid);
      end
      check("fl_lost", 32'(seen), 32'd0);
    end

    // Asynchronous reset in the middle of a stalled transfer.
    i_ready = 1'b0;
    drive(32'h4020_0000, W, 3'b011, 5'd7);
    @(negedge i_clk);
    i_valid = 1'b0;
    wait_valid("ar");
    check("ar_pre_res", o_result, 32'd3);
    #2 i_rst_n = 1'b0;
    #1;
    check("ar_valid",  {31'd0, o_valid}, 32'd0);
    check("ar_result", o_result, 32'd0);
    check("ar_rd",     {27'd0, o_rd_addr}, 32'd0);
    check("ar_flags",  {27'd0, o_fflags}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("ar_idle",   {31'd0, o_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_cvt_f2i.md
# fpu_cvt_f2i

Two-stage pipelined float-to-integer converter implementing RV32F FCVT.W.S and FCVT.WU.S, with all five rounding modes, RISC-V saturation rules and exception flags. It is the counterpart of the FPU sign-injection logic. Where sign injection builds float bit patterns, this block reads single-precision patterns back out as 32-bit integers. It sits in the FPU execute slot. It has a valid/ready handshake toward the issue stage and toward writeback, and carries the destination register tag alongside the data.

## Interface
- No parameters.
- i_clk  in  1  core clock; every register updates on its rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_flush  in  1  kills all in-flight operations.
- i_valid  in  1  input operation present.
- o_ready  out  1  block accepts the input this cycle.
- i_operand_a  in  32  IEEE-754 single-precision source.
- i_alu_op  in  5  5'b10100 = FCVT.W.S, 5'b10101 = FCVT.WU.S.
- i_rm  in  3  resolved rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; values 101–111 behave as RNE.
- i_rd_addr  in  5  destination tag, passed through unchanged.
- o_valid  out  1  result present.
- i_ready  in  1  writeback accepts the result.
- o_result  out  32  integer result.
- o_rd_addr  out  5  tag associated with o_result.
- o_fflags  out  5  {NV, DZ, OF, UF, NX}; DZ, OF and UF are always 0.

## Operation
- Stage 1 (S1) unpacks the operand:
  - sign, and unbiased exponent e = exp − 127;
  - 24-bit significand; the hidden bit is 0 for denormals, which use e = −126;
  - classification: NaN, infinity, zero.
- S1 produces the aligned integer plus guard and sticky bits, and registers them with op, rm and tag.
  - e ≥ 23: left-shift by e − 23.
  - e < 23: right-shift by 23 − e; guard = first bit shifted out; sticky = OR of the remaining shifted-out bits.
  - e < −1: integer part 0, guard 0, sticky = (significand ≠ 0).
- Stage 2 (S2) rounds the magnitude:
  - increment if RNE and guard && (sticky || lsb);
  - increment if RMM and guard;
  - increment if RUP and positive and (guard || sticky);
  - increment if RDN and negative and (guard || sticky);
  - RTZ never increments.
- S2 then negates if the sign is set, saturates and sets flags.
- W saturation:
  - NaN or +∞ → 0x7FFFFFFF, NV;
  - −∞ → 0x80000000, NV;
  - rounded value > 2^31−1 → 0x7FFFFFFF, NV;
  - rounded value < −2^31 → 0x80000000, NV;
  - exactly −2^31 is valid with no NV.
- WU saturation:
  - NaN, +∞, or value > 2^32−1 → 0xFFFFFFFF, NV;
  - negative input whose rounded magnitude is ≥ 1 → 0, NV;
  - negative input that rounds to 0 → 0, NX only.
- NX = (guard || sticky) && !NV. Zero inputs of either sign → 0, no flags.
- Any other i_alu_op value passes through the pipeline and yields result 0, flags 0.

## Timing
- Latency is 2 cycles from acceptance (i_valid && o_ready) to o_valid. Throughput is 1 operation per cycle.
- Stall rules:
  - S2 holds while o_valid && !i_ready.
  - S1 advances when S2 is empty or draining.
  - o_ready = !s1_valid || s1_advance, computed combinationally.
- o_result, o_rd_addr and o_fflags stay stable while o_valid && !i_ready.
- i_flush clears both valid bits on the next edge. Input presented in the same cycle is discarded. Flush has priority over accept and drain.
- Reset values: o_valid 0, o_result 0, o_rd_addr 0, o_fflags 0; internal valids 0. An assertion mid-operation drops all in-flight work immediately.
- Operations leave the block in the order they were accepted. Nothing is duplicated or lost except by flush or reset.

## Configuration
- FPU_CVT_FFLAGS_EN defined: o_fflags is driven as described above.
- FPU_CVT_FFLAGS_EN undefined: o_fflags is tied to 5'b0 and the flag registers are removed. Results and saturation values are unchanged.

## Structure
- The shared package fpu_pkg holds:
  - the ALU-op constants (FCVT_W, FCVT_WU, and the sign-injection codes);
  - the rounding-mode enum rm_e;
  - the flag bit indices;
  - the saturation constants INT_MAX, INT_MIN, UINT_MAX.
- One sub-module, fpu_round_sat, contains the combinational S2 logic (round, negate, saturate, flags). The top level keeps both pipeline registers and the handshake.

## Test plan
- 0x40200000 (2.5), W:
  - RNE → 2, NX;
  - RUP → 3, NX;
  - RMM → 3, NX;
  - RTZ → 2, NX.
- 0xC0200000 (−2.5), W, RDN → 0xFFFFFFFD, NX.
- Boundaries:
  - 0xCF000000, W → 0x80000000, no flags;
  - 0x4F000000, W → 0x7FFFFFFF, NV;
  - 0x4F000000, WU → 0x80000000, no flags.
- Special and negative WU inputs:
  - 0x7FC00000 → W 0x7FFFFFFF, NV;
  - 0x7FC00000 → WU 0xFFFFFFFF, NV;
  - 0xBF000000 (−0.5), WU, RTZ → 0, NX;
  - 0xBF000000 (−0.5), WU, RDN → 0, NV.
- Three back-to-back ops with tags 1, 2, 3, and i_ready low for two cycles:
  - results hold stable, o_ready drops when both stages are full;
  - results emerge with tags 1, 2, 3 in order.
- Flush and reset:
  - i_flush with both stages full plus a new input → o_valid 0 on the next cycle and the new input is lost;
  - i_rst_n pulsed mid-stream → all outputs return to 0 asynchronously.
